// File: rtl/la_pkg.sv
// Shared types and constants for the PCI logic-analyzer capture path.
package la_pkg;

  localparam int LA_SAMPLE_W = 48;
  localparam int LA_ADDR_W   = 8;
  localparam int LA_CNT_W    = 8;

  // Layout of one captured PCI bus snapshot
  localparam int LA_AD_LSB     = 0;
  localparam int LA_AD_W       = 32;
  localparam int LA_CBE_LSB    = 32;
  localparam int LA_CBE_W      = 4;
  localparam int LA_FRAME_BIT  = 36;
  localparam int LA_IRDY_BIT   = 37;
  localparam int LA_TRDY_BIT   = 38;
  localparam int LA_DEVSEL_BIT = 39;
  localparam int LA_STOP_BIT   = 40;
  localparam int LA_PAR_BIT    = 41;
  localparam int LA_IDSEL_BIT  = 42;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } la_state_e;

endpackage

// File: rtl/la_trig_match.sv
// Masked pattern compare plus external qualifier; the hit is registered so it
// lines up with the registered sample being written to RAM.
module la_trig_match
  import la_pkg::*;
#(
  parameter int W = LA_SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sample,
  input  logic         ext_trig,
  input  logic [W-1:0] value,
  input  logic [W-1:0] mask,
  input  logic         ext_en,
  output logic         hit
);

  logic match_c;

  assign match_c = (((sample ^ value) & mask) == '0) | (ext_en & ext_trig);

  always_ff @(posedge clk) begin
    if (rst) hit <= 1'b0;
    else     hit <= match_c;
  end

endmodule

// File: rtl/la_capture_ctrl.sv
// Pre/post-trigger ring-buffer capture controller feeding the acquisition RAM.
//
// state | meaning
// IDLE  | no capture, RAM not written
// FILL  | writing the pre-trigger history, hits ignored
// ARMED | ring buffer running, counting hits toward the trigger
// POST  | writing the post-trigger samples
// DONE  | capture complete, addresses held for readout
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int SAMPLE_W = LA_SAMPLE_W,
  parameter int ADDR_W   = LA_ADDR_W,
  parameter int CNT_W    = LA_CNT_W
) (
  input  logic                PCI_CLK,
  input  logic                PCI_RST,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                ext_trig,
  input  logic                arm,
  input  logic                abort,
  input  logic [SAMPLE_W-1:0] cfg_value,
  input  logic [SAMPLE_W-1:0] cfg_mask,
  input  logic                cfg_ext_en,
  input  logic [CNT_W-1:0]    cfg_occ,
  input  logic [ADDR_W-1:0]   cfg_post,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [SAMPLE_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic [ADDR_W-1:0]   start_addr,
  output logic                busy,
  output logic                done
);

  la_state_e state, state_n;

  logic [SAMPLE_W-1:0] sample_r;
  logic [SAMPLE_W-1:0] value_l, mask_l;
  logic                ext_en_l;
  logic [CNT_W-1:0]    occ_l, occ, occ_n, occ_sat;
  logic [CNT_W:0]      occ_inc, occ_goal;
  logic [ADDR_W-1:0]   post_l, pre_l, post_cnt, wptr;
  logic                start_acq, take_trig, hit;

  // Config seen by the matcher switches to the new values on the arm edge, so
  // the first hit evaluated in the new acquisition already uses them.
  logic [SAMPLE_W-1:0] value_eff, mask_eff;
  logic                ext_en_eff;

  assign start_acq  = arm & ~abort;
  assign value_eff  = start_acq ? cfg_value  : value_l;
  assign mask_eff   = start_acq ? cfg_mask   : mask_l;
  assign ext_en_eff = start_acq ? cfg_ext_en : ext_en_l;

  la_trig_match #(.W(SAMPLE_W)) u_match (
    .clk      (PCI_CLK),
    .rst      (PCI_RST),
    .sample   (sample),
    .ext_trig (ext_trig),
    .value    (value_eff),
    .mask     (mask_eff),
    .ext_en   (ext_en_eff),
    .hit      (hit)
  );

  assign pre_l    = {ADDR_W{1'b1}} - post_l;
  assign occ_inc  = {1'b0, occ} + 1'b1;
  assign occ_goal = (occ_l == '0) ? (CNT_W+1)'(1) : {1'b0, occ_l};
  assign occ_sat  = (&occ) ? occ : occ + 1'b1;

  assign ram_we     = (state == FILL) || (state == ARMED) || (state == POST);
  assign busy       = ram_we;
  assign done       = (state == DONE);
  assign ram_addr   = wptr;
  assign ram_wdata  = sample_r;

  always_ff @(posedge PCI_CLK) begin
    if (PCI_RST) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n   = state;
    occ_n     = occ;
    take_trig = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else if (arm) begin
      state_n = (&cfg_post) ? ARMED : FILL;
    end else begin
      case (state)
        FILL: begin
          if (wptr == pre_l - 1'b1) state_n = ARMED;
        end
        ARMED: begin
          if (hit) begin
            occ_n = occ_sat;
            if (occ_inc == occ_goal) begin
              take_trig = 1'b1;
              state_n   = (post_l == '0) ? DONE : POST;
            end
          end
        end
        POST: begin
          if (post_cnt == ADDR_W'(1)) state_n = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCI_CLK) begin
    if (PCI_RST) begin
      sample_r   <= '0;
      value_l    <= '0;
      mask_l     <= '0;
      ext_en_l   <= 1'b0;
      occ_l      <= '0;
      post_l     <= '0;
      occ        <= '0;
      post_cnt   <= '0;
      wptr       <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
    end else begin
      sample_r <= sample;
      if (start_acq) begin
        value_l  <= cfg_value;
        mask_l   <= cfg_mask;
        ext_en_l <= cfg_ext_en;
        occ_l    <= cfg_occ;
        post_l   <= cfg_post;
        occ      <= '0;
        post_cnt <= '0;
        wptr     <= '0;
      end else if (!abort) begin
        if (ram_we) wptr <= wptr + 1'b1;
        occ <= occ_n;
        if (take_trig) begin
          trig_addr  <= wptr;
          start_addr <= wptr - pre_l;
          post_cnt   <= post_l;
        end else if (state == POST) begin
          post_cnt <= post_cnt - 1'b1;
        end
      end
    end
  end

endmodule
